// File: rtl/bf_program_loader.sv
// Program-memory loader for the BF machine: takes debounced switch opcodes, tracks
// bracket depth, appends HALT on Finish and raises PMInputDone for the control unit.
module bf_program_loader #(
  parameter int PMAW = 8,
  parameter int OPW  = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [OPW-1:0]  SwitchOp,
  input  logic            Enter,
  input  logic            Finish,
  input  logic            Clear,
  output logic [PMAW-1:0] PMAddress,
  output logic [OPW-1:0]  PMData,
  output logic            PMWren,
  output logic            PMInputDone,
  output logic            BracketError,
  output logic            Full,
  output logic [PMAW-1:0] ProgLen
);

  typedef enum logic [2:0] {LOAD, WRITE, WHALT, DONE, ERROR} state_t;

  localparam logic [OPW-1:0] OP_OPEN  = OPW'(5);
  localparam logic [OPW-1:0] OP_CLOSE = OPW'(6);
  localparam logic [OPW-1:0] OP_LAST  = OPW'(8);

  state_t          state_reg, state_next;
  logic [2:0]      sync1_reg, sync2_reg, prev_reg;
  logic [2:0]      evt;
  logic            enter_evt, finish_evt, clear_evt;
  logic [PMAW-1:0] addr_reg, addr_next;
  logic [PMAW-1:0] depth_reg, depth_next;
  logic [PMAW-1:0] len_reg, len_next;
  logic [OPW-1:0]  data_reg, data_next;
  logic            wren_reg, wren_next;
  logic            pending_reg, pending_next;
  logic            done_reg, err_reg;
  logic            op_valid, full;

  // Bit order {Clear, Finish, Enter}; an event is the first cycle sync2 sees a press.
  assign evt        = sync2_reg & ~prev_reg;
  assign enter_evt  = evt[0];
  assign finish_evt = evt[1];
  assign clear_evt  = evt[2];

  assign op_valid = (SwitchOp != '0) && (SwitchOp <= OP_LAST);
  assign full     = (addr_reg == {PMAW{1'b1}});

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_reg   <= '0;
      sync2_reg   <= '0;
      prev_reg    <= '0;
      state_reg   <= LOAD;
      addr_reg    <= '0;
      depth_reg   <= '0;
      len_reg     <= '0;
      data_reg    <= '0;
      wren_reg    <= 1'b0;
      pending_reg <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      sync1_reg   <= {Clear, Finish, Enter};
      sync2_reg   <= sync1_reg;
      prev_reg    <= sync2_reg;
      state_reg   <= state_next;
      addr_reg    <= addr_next;
      depth_reg   <= depth_next;
      len_reg     <= len_next;
      data_reg    <= data_next;
      wren_reg    <= wren_next;
      pending_reg <= pending_next;
      done_reg    <= !clear_evt && (state_reg == DONE);
      err_reg     <= !clear_evt && (state_reg == ERROR);
    end
  end

  always_comb begin
    state_next   = state_reg;
    addr_next    = addr_reg;
    depth_next   = depth_reg;
    len_next     = len_reg;
    data_next    = data_reg;
    wren_next    = 1'b0;
    pending_next = pending_reg;
    if (clear_evt) begin
      state_next   = LOAD;
      addr_next    = '0;
      depth_next   = '0;
      len_next     = '0;
      pending_next = 1'b0;
    end else begin
      case (state_reg)
        LOAD: begin
          if (enter_evt && op_valid && !full) begin
            if (SwitchOp == OP_CLOSE && depth_reg == '0) begin
              state_next   = ERROR;
              pending_next = 1'b0;
            end else begin
              if (SwitchOp == OP_OPEN)  depth_next = depth_reg + 1'b1;
              if (SwitchOp == OP_CLOSE) depth_next = depth_reg - 1'b1;
              wren_next  = 1'b1;
              data_next  = SwitchOp;
              state_next = WRITE;
              // A Finish arriving with this write is serviced once the address has advanced.
              if (finish_evt) pending_next = 1'b1;
            end
          end else if (finish_evt || pending_reg) begin
            wren_next    = 1'b1;
            data_next    = '0;
            pending_next = 1'b0;
            state_next   = WHALT;
          end
        end
        WRITE: begin
          addr_next  = addr_reg + 1'b1;
          len_next   = len_reg + 1'b1;
          state_next = LOAD;
          if (finish_evt) pending_next = 1'b1;
        end
        WHALT:   state_next = (depth_reg == '0) ? DONE : ERROR;
        DONE:    state_next = DONE;
        ERROR:   state_next = ERROR;
        default: state_next = LOAD;
      endcase
    end
  end

  assign PMAddress    = addr_reg;
  assign PMData       = data_reg;
  assign PMWren       = wren_reg;
  assign PMInputDone  = done_reg;
  assign BracketError = err_reg;
  assign Full         = full;
  assign ProgLen      = len_reg;

endmodule
